// File: rtl/tcb_uart_pkg.sv
// Shared definitions for the TCB UART receive deserializer and transmit serializer.
package tcb_uart_pkg;

    // Frame defaults: 8 data bits, 1 stop bit.
    localparam int UART_DW        = 8;
    localparam int UART_STOP_BITS = 1;

    // Receive frame state machine.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_des_state_t;

endpackage : tcb_uart_pkg

// File: rtl/tcb_sync.sv
// Generic two-flop synchronizer with a programmable reset value.
// Only compiled into the build when TCB_UART_DES_SYNC_EN is defined,
// since the deserializer is its sole user.
`ifdef TCB_UART_DES_SYNC_EN
module tcb_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    // Two-stage capture of the asynchronous input.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule : tcb_sync
`endif

// File: rtl/tcb_uart_des.sv
// UART receive deserializer: recovers 8N1-style frames from uart_rxd using a
// programmable bit period (cfg_bdr) and sample point (cfg_smp), and presents
// each word on a single-entry valid/ready output register.
//
// Handshake: a word transfers on any cycle where str_vld && str_rdy are both
// high; str_dat is held stable while str_vld is high and str_rdy is low.
//
// Build option TCB_UART_DES_SYNC_EN: insert a 2-flop synchronizer (reset to 1)
// on uart_rxd, delaying all timing by 2 cycles. Undefined: uart_rxd is used as is.
module tcb_uart_des
    import tcb_uart_pkg::*;
#(
    parameter int DW = UART_DW,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [CW-1:0] cfg_bdr,
    input  logic [CW-1:0] cfg_smp,
    input  logic          uart_rxd,
    output logic          str_vld,
    output logic [DW-1:0] str_dat,
    input  logic          str_rdy,
    output logic          err_frm,
    output logic          err_ovr,
    output logic          busy
);

    localparam int            BW       = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [BW-1:0] BIT_LAST = BW'(DW - 1);

    logic rxd;

`ifdef TCB_UART_DES_SYNC_EN
    tcb_sync #(.RST_VAL(1'b1)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (uart_rxd),
        .q   (rxd)
    );
`else
    assign rxd = uart_rxd;
`endif

    uart_des_state_t state;
    uart_des_state_t state_nxt;

    logic [CW-1:0] cnt;
    logic [CW-1:0] smp_pt;
    logic [BW-1:0] bit_idx;
    logic [DW-1:0] sreg;
    logic          rxd_prv;
    logic          fall;
    logic          smp_hit;
    logic          wrap;
    logic          word_done;

    // A sample point beyond the bit period is clamped to the last cycle of the bit.
    assign smp_pt    = (cfg_smp > cfg_bdr) ? cfg_bdr : cfg_smp;
    assign smp_hit   = (cnt == smp_pt);
    // >= rather than == so a period shortened mid-frame still wraps.
    assign wrap      = (cnt >= cfg_bdr);
    assign fall      = rxd_prv & ~rxd;
    assign word_done = (state == ST_STOP) && smp_hit && rxd;
    assign busy      = (state != ST_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; STOP leaves at its sample point so an early start edge is caught.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (fall) state_nxt = ST_START;
            ST_START: begin
                if (smp_hit && rxd) state_nxt = ST_IDLE;
                else if (wrap)      state_nxt = ST_DATA;
            end
            ST_DATA:  if (wrap && (bit_idx == BIT_LAST)) state_nxt = ST_STOP;
            ST_STOP:  if (smp_hit) state_nxt = rxd ? ST_IDLE : ST_BREAK;
            ST_BREAK: if (rxd) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Bit timing: cnt is 0 on the edge-detect cycle, so it restarts at 0 whenever IDLE is next.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= '0;
            rxd_prv <= 1'b1;
        end else begin
            rxd_prv <= rxd;
            if (state_nxt == ST_IDLE) cnt <= '0;
            else if (wrap)            cnt <= '0;
            else                      cnt <= cnt + 1'b1;
            if (state == ST_START)           bit_idx <= '0;
            else if (state == ST_DATA && wrap) bit_idx <= bit_idx + 1'b1;
        end
    end

    // Shift register: data arrives LSB first, so shift in at the MSB and move right.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                sreg <= '0;
        else if (state == ST_DATA && smp_hit) sreg <= {rxd, sreg[DW-1:1]};
    end

    // Output register and error pulses; a word arriving while the old one is stalled is dropped.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            str_vld <= 1'b0;
            str_dat <= '0;
            err_frm <= 1'b0;
            err_ovr <= 1'b0;
        end else begin
            err_frm <= (state == ST_STOP) && smp_hit && !rxd;
            err_ovr <= 1'b0;
            if (word_done) begin
                if (!str_vld || str_rdy) begin
                    str_vld <= 1'b1;
                    str_dat <= sreg;
                end else begin
                    err_ovr <= 1'b1;
                end
            end else if (str_vld && str_rdy) begin
                str_vld <= 1'b0;
            end
        end
    end

endmodule : tcb_uart_des

// File: tb/tb_tcb_uart_des.sv
// Testbench for tcb_uart_des (default build), cfg_bdr=3 / cfg_smp=1: 4 cycles per bit.
module tb_tcb_uart_des;

    logic        clk;
    logic        rst;
    logic [15:0] cfg_bdr;
    logic [15:0] cfg_smp;
    logic        uart_rxd;
    logic        str_vld;
    logic [7:0]  str_dat;
    logic        str_rdy;
    logic        err_frm;
    logic        err_ovr;
    logic        busy;

    tcb_uart_des #(.DW(8), .CW(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .cfg_bdr  (cfg_bdr),
        .cfg_smp  (cfg_smp),
        .uart_rxd (uart_rxd),
        .str_vld  (str_vld),
        .str_dat  (str_dat),
        .str_rdy  (str_rdy),
        .err_frm  (err_frm),
        .err_ovr  (err_ovr),
        .busy     (busy)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor state, sampled on the falling edge.
    logic [7:0] rx_q[$];
    logic [7:0] exp_q[$];
    int vld_cnt, frm_cnt, ovr_cnt, first_vld_rel, start_cyc;
    int tests = 0;
    int failed = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (str_vld && str_rdy) rx_q.push_back(str_dat);
            if (str_vld) begin
                vld_cnt = vld_cnt + 1;
                if (first_vld_rel < 0) first_vld_rel = cyc - start_cyc;
            end
            if (err_frm) frm_cnt = frm_cnt + 1;
            if (err_ovr) ovr_cnt = ovr_cnt + 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests = tests + 1;
        if (act != exp) begin
            failed = failed + 1;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rxd(input logic v, input int n);
        uart_rxd = v;
        repeat (n) tick();
    endtask

    task automatic clear_mon();
        rx_q.delete();
        exp_q.delete();
        vld_cnt = 0;
        frm_cnt = 0;
        ovr_cnt = 0;
        first_vld_rel = -1;
    endtask

    // Drive one frame: start bit, 8 data bits LSB first, stop bit of given value/length.
    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_len);
        start_cyc = cyc;
        set_rxd(1'b0, 4);
        for (int i = 0; i < 8; i++) set_rxd(d[i], 4);
        set_rxd(stop_v, stop_len);
    endtask

    // Scoreboard: received words against expected queue, in order.
    task automatic compare_words(input string name);
        check({name, "_count"}, rx_q.size(), exp_q.size());
        while (rx_q.size() > 0 && exp_q.size() > 0) begin
            logic [7:0] a, e;
            a = rx_q.pop_front();
            e = exp_q.pop_front();
            check({name, "_data"}, int'(a), int'(e));
        end
    endtask

    typedef struct {
        logic [7:0] dat;
        logic       stop;
        int         exp_words;
        int         exp_frm;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{dat: 8'h48, stop: 1'b1, exp_words: 1, exp_frm: 0};
        vecs[1] = '{dat: 8'h00, stop: 1'b1, exp_words: 1, exp_frm: 0};
        vecs[2] = '{dat: 8'hFF, stop: 1'b1, exp_words: 1, exp_frm: 0};
        vecs[3] = '{dat: 8'h81, stop: 1'b1, exp_words: 1, exp_frm: 0};
        vecs[4] = '{dat: 8'h55, stop: 1'b0, exp_words: 0, exp_frm: 1};

        rst      = 1'b1;
        cfg_bdr  = 16'd3;
        cfg_smp  = 16'd1;
        uart_rxd = 1'b1;
        str_rdy  = 1'b1;
        clear_mon();
        start_cyc = 0;
        #1;
        check("rst_vld",  int'(str_vld), 0);
        check("rst_dat",  int'(str_dat), 0);
        check("rst_frm",  int'(err_frm), 0);
        check("rst_ovr",  int'(err_ovr), 0);
        check("rst_busy", int'(busy), 0);
        repeat (3) tick();
        rst = 1'b0;
        repeat (3) tick();

        // Table of single frames with str_rdy=1.
        for (int v = 0; v < 5; v++) begin
            clear_mon();
            if (vecs[v].exp_words > 0) exp_q.push_back(vecs[v].dat);
            if (vecs[v].stop) begin
                send_frame(vecs[v].dat, 1'b1, 4);
            end else begin
                send_frame(vecs[v].dat, 1'b0, 8);
                check("frm_busy_in_break", int'(busy), 1);
                set_rxd(1'b1, 2);
            end
            set_rxd(1'b1, 4);
            check("vec_busy_idle", int'(busy), 0);
            check("vec_frm", frm_cnt, vecs[v].exp_frm);
            check("vec_ovr", ovr_cnt, 0);
            check("vec_vld_cycles", vld_cnt, vecs[v].exp_words);
            if (vecs[v].exp_words > 0) check("vec_vld_at_38", first_vld_rel, 38);
            compare_words("vec");
        end

        // Glitch: one low cycle on the line.
        clear_mon();
        start_cyc = cyc;
        set_rxd(1'b0, 1);
        uart_rxd = 1'b1;
        @(negedge clk);
        check("glitch_busy_c1", int'(busy), 1);
        tick();
        @(negedge clk);
        check("glitch_busy_c2", int'(busy), 0);
        set_rxd(1'b1, 40);
        check("glitch_vld", vld_cnt, 0);
        check("glitch_frm", frm_cnt, 0);

        // Overrun: two words with the consumer stalled.
        clear_mon();
        str_rdy = 1'b0;
        send_frame(8'h41, 1'b1, 4);
        send_frame(8'h42, 1'b1, 4);
        set_rxd(1'b1, 4);
        check("ovr_vld", int'(str_vld), 1);
        check("ovr_dat", int'(str_dat), 8'h41);
        check("ovr_pulses", ovr_cnt, 1);
        str_rdy = 1'b1;
        tick();
        str_rdy = 1'b0;
        @(negedge clk);
        check("ovr_vld_dropped", int'(str_vld), 0);
        exp_q.push_back(8'h41);
        compare_words("ovr");
        str_rdy = 1'b1;
        set_rxd(1'b1, 4);

        // Back-to-back frames, no idle gap.
        begin
            string msg;
            msg = "Hello, World!";
            clear_mon();
            for (int i = 0; i < msg.len(); i++) begin
                exp_q.push_back(msg[i]);
                send_frame(msg[i], 1'b1, 4);
            end
            set_rxd(1'b1, 6);
            check("b2b_frm", frm_cnt, 0);
            check("b2b_ovr", ovr_cnt, 0);
            compare_words("b2b");
        end

        // Reset during DATA bit 3 of 0xA5, then a clean 0x3C.
        begin
            logic [7:0] d;
            d = 8'hA5;
            clear_mon();
            start_cyc = cyc;
            set_rxd(1'b0, 4);
            for (int i = 0; i < 3; i++) set_rxd(d[i], 4);
            set_rxd(d[3], 2);
            check("mid_busy_before_rst", int'(busy), 1);
            check("mid_dat_before_rst", int'(str_dat), 8'h21);
            rst = 1'b1;
            #1;
            check("mid_rst_vld",  int'(str_vld), 0);
            check("mid_rst_dat",  int'(str_dat), 0);
            check("mid_rst_frm",  int'(err_frm), 0);
            check("mid_rst_ovr",  int'(err_ovr), 0);
            check("mid_rst_busy", int'(busy), 0);
            uart_rxd = 1'b1;
            tick();
            tick();
            rst = 1'b0;
            set_rxd(1'b1, 4);
            clear_mon();
            exp_q.push_back(8'h3C);
            send_frame(8'h3C, 1'b1, 4);
            set_rxd(1'b1, 6);
            check("mid_frm", frm_cnt, 0);
            compare_words("mid");
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule : tb_tcb_uart_des

// File: doc/tcb_uart_des.md
Name: tcb_uart_des

Overview:
- UART receive deserializer for the TCB UART peripheral.
- Samples the serial input (uart_rxd), recovers 8N1-style frames using a software-programmed bit period and sample point, and presents each received word on a valid/ready stream.
- The downstream consumer is the RX FIFO inside the TCB UART; the RX baudrate and RX sample registers drive its configuration inputs directly.

Parameters:
- DW, 8, data bits per frame (LSB first).
- CW, 16, width of the bit-timing counter and configuration inputs.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous reset, active-high.
- cfg_bdr  input  CW  bit period minus one, in clk cycles.
- cfg_smp  input  CW  sample point within a bit, minus one.
- uart_rxd  input  1  serial receive line (idle high).
- str_vld  output  1  received word valid.
- str_dat  output  DW  received word.
- str_rdy  input  1  consumer ready.
- err_frm  output  1  one-cycle pulse on framing error (stop bit sampled 0).
- err_ovr  output  1  one-cycle pulse when a complete word is dropped.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Clock and reset:
  - One clock domain (clk).
  - rst is asynchronous and active-high.
  - Reset values: state=IDLE, cnt=0, bit index=0, rxd_prv=1, str_vld=0, str_dat=0, err_frm=0, err_ovr=0, busy=0.
- Reset mid-frame aborts the frame and discards the partial word.
- Bit timing:
  - cnt counts 0..cfg_bdr and wraps to 0; each wrap advances the bit index.
  - The line is sampled when cnt==min(cfg_smp, cfg_bdr).
- States:
  - IDLE:
    - When rxd_prv==1 and uart_rxd==0 (falling edge), go to START.
    - That detection cycle is cnt=0.
  - START:
    - At the sample point: uart_rxd==1 means a glitch; return to IDLE with no output and no error.
    - uart_rxd==0 means a valid start bit; at the cnt wrap, go to DATA with bit index=0.
  - DATA:
    - At each sample point, shift uart_rxd into the shift register MSB and right-shift, so the word is LSB first.
    - After the sample of bit DW-1, at the cnt wrap, go to STOP.
  - STOP:
    - At the sample point, uart_rxd==1 means the frame is valid: deliver the word and go to IDLE in the next cycle. The state does not wait for the end of the stop bit, so it can resync to an early next start edge.
    - uart_rxd==0 means framing error: pulse err_frm, discard the word, go to BREAK.
  - BREAK: stay until uart_rxd==1, then go to IDLE.
- Output register (single entry):
  - The delivered word is loaded on the clock edge ending the stop-sample cycle, so str_vld rises the following cycle.
  - A transfer occurs when str_vld && str_rdy; str_vld then clears unless a new word loads in the same cycle.
  - New word with str_vld=0, or with str_vld=1 and str_rdy=1: load it, str_vld=1, no overrun.
  - New word with str_vld=1 and str_rdy=0: the new word is dropped, the old word is held, err_ovr pulses one cycle.
  - str_dat is stable while str_vld && !str_rdy.
- Configuration:
  - Software changes cfg_* only while busy=0.
  - Mid-frame changes take effect immediately; the result is unspecified but must not lock up the state machine.

Optional Feature:
- Macro: TCB_UART_DES_SYNC_EN.
- Defined: a 2-flop synchronizer on uart_rxd, both flops reset to 1. All timing shifts by +2 cycles relative to the pin.
- Undefined: uart_rxd is used directly, for the synchronous loopback case.

Decomposition:
- tcb_uart_pkg holds:
  - the state enum typedef (IDLE, START, DATA, STOP, BREAK);
  - UART default constants (DW=8, stop bits=1).
- The shared transmit serializer later reuses this package.
- No sub-module is needed; the timing counter, shift register and output register stay inline.
- When TCB_UART_DES_SYNC_EN is defined, the synchronizer is a generic tcb_sync sub-module.

Test Plan (macro undefined, cfg_bdr=3, cfg_smp=1):
- Single frame: drive 0x48 ('H'), 4 cycles per bit, falling edge at cycle 0, str_rdy=1 -> str_vld high at cycle 38 only, str_dat=0x48, no error pulses.
- Glitch: uart_rxd low for 1 cycle (cycle 0) -> START aborts at cycle 1, busy low by cycle 2, no str_vld, no err_frm.
- Framing error: frame 0x55 with stop bit 0 -> err_frm pulses once, no str_vld, busy stays high until uart_rxd returns to 1.
- Overrun: frames 0x41 then 0x42 with str_rdy=0 -> str_dat stays 0x41, err_ovr pulses once at the second delivery. Then str_rdy=1 for 1 cycle -> str_vld drops.
- Back-to-back: transmit "Hello, World!" (13 bytes, no idle gap) with str_rdy=1 -> 13 transfers matching in order, no errors.
- Reset mid-frame: assert rst during DATA bit 3 of 0xA5, then send 0x3C -> only 0x3C delivered, with all outputs at reset values during rst.
